// File: rtl/req_encoder.sv
// Serialises per-line request pulses into a registered binary code stream with valid/ready.
// Define REQ_ENCODER_ROUND_ROBIN_EN for round-robin selection instead of lowest-index-first.
module req_encoder #(
    parameter int unsigned N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_code,
    output logic [N-1:0]         pending_o,
    output logic                 dup_o,
    output logic [7:0]           served_cnt
);
    localparam int unsigned W = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t         state_q;
    logic [N-1:0]   pending_q, pending_d;
    logic [W-1:0]   code_q;
    logic           dup_q, dup_d;
    logic [7:0]     cnt_q;
    logic [W-1:0]   sel_idx;
    logic           sel_found;
    logic           load;
    logic           xfer;
    logic [N-1:0]   clr;

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
    logic [W-1:0]   last_gnt_q;
    logic [W-1:0]   probe;

    // Search starts one past the last grant; W-bit arithmetic wraps modulo N.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        probe     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            probe = last_gnt_q + W'(1) + W'(i);
            if (!sel_found && pending_q[probe]) begin
                sel_idx   = probe;
                sel_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt_q <= W'(N - 1);
        end else if (load) begin
            last_gnt_q <= sel_idx;
        end
    end
`else
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!sel_found && pending_q[i]) begin
                sel_idx   = W'(i);
                sel_found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        xfer = (state_q == HOLD) && out_ready;
        load = (|pending_q) && ((state_q == IDLE) || out_ready);
        clr  = '0;
        if (load) begin
            clr[sel_idx] = 1'b1;
        end
        // A request arriving on the line being cleared wins and stays pending.
        pending_d = (pending_q & ~clr) | req_i;
        dup_d     = |(req_i & pending_q & ~clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            code_q    <= '0;
            dup_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            dup_q     <= dup_d;
            if (xfer) begin
                cnt_q <= cnt_q + 8'd1;
            end
            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q <= HOLD;
                        code_q  <= sel_idx;
                    end
                end
                HOLD: begin
                    if (load) begin
                        code_q <= sel_idx;
                    end else if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid  = (state_q == HOLD);
    assign out_code   = code_q;
    assign pending_o  = pending_q;
    assign dup_o      = dup_q;
    assign served_cnt = cnt_q;

endmodule

// File: doc/req_encoder.md
Name: req_encoder

Overview:
- Encoder-side companion to the team's 2-to-4 decoder: turns N request lines into a registered binary index stream.
- Input: per-line request pulses. Each pulse is latched as pending. Pending lines are served one at a time.
- Output: binary code of the served line, delivered with a valid/ready handshake.
- Sits in front of the decoder/consumer logic, so events from several sources are serialised into one code channel.

Parameters:
- N, 4, number of request lines (≥2, power of two).
- W, $clog2(N) (2 at default), width of the output code. Derived; not overridden.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_i  input  N  request pulses; bit k high for one cycle = one event on line k.
- out_valid  output  1  out_code holds an unconsumed code.
- out_ready  input  1  consumer accepts the code this cycle.
- out_code  output  W  binary index of the served line.
- pending_o  output  N  current pending register (debug/status).
- dup_o  output  1  one-cycle pulse: a request hit a line that was already pending and not being cleared (event merged).
- served_cnt  output  8  count of completed handshakes; wraps 255→0.

Behaviour:
- Reset (rst_n=0 at a clk edge) sets: pending=0, out_valid=0, out_code=0, dup_o=0, served_cnt=0. Round-robin pointer (if present) = N-1.
- Reset mid-transfer discards the held code and all pending requests. No handshake is counted.
- Pending update each cycle: pending_next = (pending & ~clr) | req_i.
  - clr is the one-hot bit of the line loaded into the output register this cycle.
  - If req_i[k] and clr[k] are both set in the same cycle, the request wins: bit stays set and counts as a new event.
- dup_o (registered) is high in cycle t+1 when, in cycle t, req_i[k] & pending[k] & ~clr[k] holds for any k.
- Load condition: load = (|pending) & (~out_valid | out_ready).
  - On load: out_code ← selected index, clr = onehot(selected), out_valid ← 1.
  - Otherwise, if out_valid & out_ready: out_valid ← 0.
- Two-state FSM:
  - IDLE (out_valid=0) → HOLD on load.
  - HOLD (out_valid=1) → HOLD on handshake with a load (back-to-back).
  - HOLD → IDLE on handshake with pending=0.
  - HOLD → HOLD while out_ready=0; out_code stays stable.
- Handshake: transfer when out_valid & out_ready at a clk edge. served_cnt increments by 1 (mod 256) on every transfer.
- Latency: req_i pulse at edge t → pending at t+1 → out_valid at t+2, if the output is free.
- Throughput: one code per cycle while out_ready=1 and pending is nonzero.
- Selection (default): fixed priority, lowest index first.
- out_ready while out_valid=0 has no effect.
- req_i all zero with pending=0: outputs hold; no activity.

Optional Feature:
- Macro: REQ_ENCODER_ROUND_ROBIN_EN.
- Defined:
  - W-bit pointer last_gnt, updated to the selected index on every load.
  - Search starts at (last_gnt+1) mod N and wraps.
  - After reset the search starts at index 0, because last_gnt resets to N-1.
- Undefined: no pointer register; fixed lowest-index priority.

Test Plan:
- Reset then single event: req_i=4'b0100 for 1 cycle, out_ready=1 → out_valid=1 with out_code=2 exactly 2 cycles after the pulse, for 1 cycle; served_cnt=1; pending_o=0.
- Simultaneous events, fixed priority: req_i=4'b1011 in one cycle, out_ready=1 → codes 0,1,3 on consecutive cycles; then out_valid=0; served_cnt=3.
- Backpressure: one pending event, out_ready=0 for 5 cycles → out_valid and out_code held stable. A new req on line 1 meanwhile sets pending_o[1]. Raising out_ready drains both, in priority order.
- Duplicate/merge: req_i[3] pulsed twice while line 3 is pending and the output is stalled → dup_o pulses once; only one code 3 is emitted.
- Request-on-clear race: re-pulse req_i[0] in the cycle line 0 is loaded → dup_o=0; code 0 is emitted twice. Reset asserted while out_valid=1 → next cycle out_valid=0, pending_o=0, served_cnt=0.
- With REQ_ENCODER_ROUND_ROBIN_EN: hold req_i=4'b1111 continuously, out_ready=1 → codes cycle 0,1,2,3,0,…; served_cnt wraps 255→0 after 256 transfers.
